// File: rtl/scan_pkg.sv
// Shared encodings and defaults for the 1011 word scanner.
// The SCAN_OVERLAP_EN macro, used in seq_det_1011, selects overlapping detection.
package scan_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } det_t;

    // A WIDTH-bit word holds at most WIDTH/3+1 matches, so this width never overflows.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/scan_1011_ctrl_if.sv
// Word-in / count-out handshake bundle for scan_1011_ctrl.
// master drives words and takes results; slave is the controller.
interface scan_1011_ctrl_if
    import scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic                      out_valid;
    logic [$clog2(WIDTH):0]    out_count;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, busy
    );
endinterface

// File: rtl/seq_det_1011.sv
// Mealy detector for the bit pattern 1011, one bit per enabled cycle.
// SCAN_OVERLAP_EN lets the final 1 of a match start the next one.
module seq_det_1011
    import scan_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic hit
);

    det_t st;

    assign hit = en && din && (st == D3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= D0;
        end else if (clr) begin
            st <= D0;
        end else if (en) begin
            case (st)
                D0: st <= din ? D1 : D0;
                D1: st <= din ? D1 : D2;
                D2: st <= din ? D3 : D0;
                D3: begin
`ifdef SCAN_OVERLAP_EN
                    st <= din ? D1 : D2;
`else
                    st <= din ? D0 : D2;
`endif
                end
                default: st <= D0;
            endcase
        end
    end

endmodule

// File: rtl/scan_1011_ctrl.sv
// Accepts a word, shifts it MSB first through seq_det_1011 and reports the match count.
// Overlapping detection is selected by SCAN_OVERLAP_EN inside the detector.
module scan_1011_ctrl
    import scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    scan_1011_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic             accept;
    logic             det_en;
    logic             hit;

    assign accept = (state == IDLE) && bus.in_valid && bus.in_ready;
    assign det_en = (state == SHIFT);

    // Clearing on accept keeps detector state from leaking between words.
    seq_det_1011 u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (det_en),
        .din   (shreg[WIDTH-1]),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bitcnt        <= '0;
            bus.out_count <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg         <= bus.in_data;
                        bitcnt        <= '0;
                        bus.out_count <= '0;
                        bus.in_ready  <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg  <= {shreg[WIDTH-2:0], 1'b0};
                    bitcnt <= bitcnt + 1'b1;
                    if (hit) begin
                        bus.out_count <= bus.out_count + 1'b1;
                    end
                    if (bitcnt == CW'(WIDTH - 1)) begin
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_1011_ctrl.sv
// Directed and random checks of scan_1011_ctrl against a window-counting model.
// Expected counts follow SCAN_OVERLAP_EN when it is defined for the build.
module tb_scan_1011_ctrl;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    scan_1011_ctrl_if #(.WIDTH(WIDTH)) bus ();

    scan_1011_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts 1011 windows in the word read MSB first; greedy skip when overlap is off.
    function automatic int model_count(input logic [WIDTH-1:0] w);
        int n;
        int i;
        logic [3:0] win;
        n = 0;
        i = WIDTH - 1;
        while (i >= 3) begin
            win = {w[i], w[i-1], w[i-2], w[i-3]};
            if (win == 4'b1011) begin
                n++;
`ifdef SCAN_OVERLAP_EN
                i = i - 3;
`else
                i = i - 4;
`endif
            end else begin
                i = i - 1;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one word, checks latency and the DONE hold, then completes the handshake.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] word,
                                 input int expected, input int hold);
        checkOutput({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        @(posedge clk);
        #1;
        for (int c = 1; c < WIDTH; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = WIDTH'($urandom);
            @(posedge clk);
            #1;
            if (c == 1 || c == WIDTH - 1) begin
                checkOutput({tag, ".shift_busy"}, 32'({bus.busy, bus.in_ready, bus.out_valid}),
                            32'b100);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, ".out_count"}, 32'(bus.out_count), 32'(expected));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = WIDTH'($urandom);
            @(posedge clk);
            #1;
            checkOutput({tag, ".hold"},
                        32'({bus.out_valid, bus.busy, bus.in_ready, bus.out_count}),
                        32'({1'b1, 1'b1, 1'b0, 4'(expected)}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, ".released"}, 32'({bus.out_valid, bus.busy, bus.in_ready}),
                    32'b001);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int               hold;
        int               exp_overlap_word;

        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_state",
                    32'({bus.out_valid, bus.busy, bus.in_ready, bus.out_count}),
                    32'({1'b0, 1'b0, 1'b1, 4'd0}));

        applyStimulus("single_match", 8'b1011_0000, 1, 0);

`ifdef SCAN_OVERLAP_EN
        exp_overlap_word = 2;
`else
        exp_overlap_word = 1;
`endif
        applyStimulus("overlap_word", 8'b1011_0110, exp_overlap_word, 0);

        applyStimulus("all_zero", 8'h00, 0, 1);
        applyStimulus("all_one", 8'hFF, 0, 0);
        applyStimulus("done_stall", 8'b1011_0000, 1, 5);

        // Reset in mid-word discards it immediately.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b1011_1011;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_shift_reset",
                    32'({bus.out_valid, bus.busy, bus.in_ready, bus.out_count}),
                    32'({1'b0, 1'b0, 1'b1, 4'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("after_reset", 8'b0000_1011, 1, 0);

        applyStimulus("cross_word_a", 8'b0000_0101, 0, 0);
        applyStimulus("cross_word_b", 8'b1000_0000, 0, 0);

        for (int k = 0; k < 24; k++) begin
            w    = WIDTH'($urandom);
            hold = int'($urandom_range(0, 3));
            applyStimulus("random", w, model_count(w), hold);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
